// File: rtl/pc_next_unit_if.sv
// Fetch request channel between the PC generator and instruction memory.
interface pc_next_unit_if #(
  parameter int XLEN = 64
);
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;

  modport master (output if_valid, output if_pc, input if_ready);
  modport slave  (input if_valid, input if_pc, output if_ready);
endinterface

// File: rtl/pc_next_unit.sv
// Fetch-stage program counter with branch/jump redirect resolution and a taken-redirect counter.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned taken targets halt fetch and raise a sticky trap.
module pc_next_unit #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int              IMM_SHIFT  = 1,
  parameter int              INSN_BYTES = 4,
  parameter int              CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  pc_next_unit_if.master    imem,
  input  logic              ex_valid_i,
  input  logic [3:0]        ex_kind_i,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  logic [XLEN-1:0]   ex_imm_i,
  input  logic [XLEN-1:0]   ex_rs1_i,
  input  logic              ex_eq_i,
  input  logic              ex_lt_i,
  input  logic              ex_ltu_i,
  output logic              redirect_o,
  output logic [XLEN-1:0]   link_addr_o,
  output logic [CNT_W-1:0]  taken_cnt_o
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic              trap_o,
  output logic [XLEN-1:0]   trap_pc_o
`endif
);

  localparam logic [3:0] K_BEQ  = 4'd1;
  localparam logic [3:0] K_BNE  = 4'd2;
  localparam logic [3:0] K_BLT  = 4'd3;
  localparam logic [3:0] K_BGE  = 4'd4;
  localparam logic [3:0] K_BLTU = 4'd5;
  localparam logic [3:0] K_BGEU = 4'd6;
  localparam logic [3:0] K_JAL  = 4'd7;
  localparam logic [3:0] K_JALR = 4'd8;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(INSN_BYTES);

`ifdef PC_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;
`else
  typedef enum logic [1:0] {BOOT, RUN} state_e;
`endif

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cond;
  logic              take;
  logic [XLEN-1:0]   jalr_sum;
  logic [XLEN-1:0]   target;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Branch condition and redirect target from the execute-stage operands
  always_comb begin
    cond = 1'b0;
    unique case (ex_kind_i)
      K_BEQ:         cond = ex_eq_i;
      K_BNE:         cond = ~ex_eq_i;
      K_BLT:         cond = ex_lt_i;
      K_BGE:         cond = ~ex_lt_i;
      K_BLTU:        cond = ex_ltu_i;
      K_BGEU:        cond = ~ex_ltu_i;
      K_JAL, K_JALR: cond = 1'b1;
      default:       cond = 1'b0;
    endcase
    jalr_sum = ex_rs1_i + ex_imm_i;
    target   = (ex_kind_i == K_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                     : ex_pc_i + (ex_imm_i << IMM_SHIFT);
    take     = ex_valid_i && (state_q == RUN) && cond;
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic            misalign;
  assign misalign = |target[1:0];
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    cnt_d      = cnt_q;
`ifdef PC_MISALIGN_TRAP_EN
    trap_d     = trap_q;
    trap_pc_d  = trap_pc_q;
`endif
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
`ifdef PC_MISALIGN_TRAP_EN
        if (take && misalign) begin
          state_d   = HALT;
          trap_d    = 1'b1;
          trap_pc_d = target;
        end else
`endif
        if (take) begin
          pc_d       = target;
          redirect_d = 1'b1;
          cnt_d      = sat_inc(cnt_q);
        end else if (imem.if_ready) begin
          pc_d = pc_q + PC_INC;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      redirect_q <= 1'b0;
      cnt_q      <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q     <= 1'b0;
      trap_pc_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      cnt_q      <= cnt_d;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q     <= trap_d;
      trap_pc_q  <= trap_pc_d;
`endif
    end
  end

  assign imem.if_valid = (state_q == RUN);
  assign imem.if_pc    = pc_q;
  assign redirect_o    = redirect_q;
  assign taken_cnt_o   = cnt_q;
  assign link_addr_o   = ex_pc_i + PC_INC;
`ifdef PC_MISALIGN_TRAP_EN
  assign trap_o        = trap_q;
  assign trap_pc_o     = trap_pc_q;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Randomized and directed bench for pc_next_unit against a behavioural fetch-PC model.
module tb_pc_next_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [3:0]  ex_kind;
  logic [63:0] ex_pc, ex_imm, ex_rs1;
  logic        ex_eq, ex_lt, ex_ltu;
  logic        redirect;
  logic [63:0] link_addr;
  logic [3:0]  taken_cnt;
`ifdef PC_MISALIGN_TRAP_EN
  logic        trap;
  logic [63:0] trap_pc;
  logic        m_trap;
  logic [63:0] m_trap_pc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_pc;
  logic        m_run, m_halt, m_redir;
  logic [3:0]  m_cnt;

  pc_next_unit_if #(.XLEN(64)) imem ();

  pc_next_unit #(
    .XLEN(64), .RESET_VEC(64'h0), .IMM_SHIFT(1), .INSN_BYTES(4), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .imem(imem),
    .ex_valid_i(ex_valid), .ex_kind_i(ex_kind), .ex_pc_i(ex_pc), .ex_imm_i(ex_imm),
    .ex_rs1_i(ex_rs1), .ex_eq_i(ex_eq), .ex_lt_i(ex_lt), .ex_ltu_i(ex_ltu),
    .redirect_o(redirect), .link_addr_o(link_addr), .taken_cnt_o(taken_cnt)
`ifdef PC_MISALIGN_TRAP_EN
    , .trap_o(trap), .trap_pc_o(trap_pc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic m_taken(input logic [3:0] k, input logic eq, input logic lt,
                                   input logic ltu);
    case (k)
      1: return eq;
      2: return !eq;
      3: return lt;
      4: return !lt;
      5: return ltu;
      6: return !ltu;
      7, 8: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] m_target(input logic [3:0] k, input logic [63:0] pc,
                                           input logic [63:0] imm, input logic [63:0] rs1);
    logic [63:0] t;
    if (k == 8) begin
      t = rs1 + imm;
      t[0] = 1'b0;
    end else begin
      t = pc + imm * 64'd2;
    end
    return t;
  endfunction

  task automatic clear_ex();
    ex_valid = 0; ex_kind = 0; ex_pc = 0; ex_imm = 0; ex_rs1 = 0;
    ex_eq = 0; ex_lt = 0; ex_ltu = 0;
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_run = 0; m_halt = 0; m_redir = 0; m_cnt = 0;
`ifdef PC_MISALIGN_TRAP_EN
    m_trap = 0; m_trap_pc = 0;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    reset = 1'b0;
  endtask

  // Advance one clock edge and update the reference model from the inputs held across it
  task automatic tick();
    logic        tk;
    logic [63:0] tg;
    logic        rdy;
    tk  = ex_valid && m_run && m_taken(ex_kind, ex_eq, ex_lt, ex_ltu);
    tg  = m_target(ex_kind, ex_pc, ex_imm, ex_rs1);
    rdy = imem.if_ready;
    @(posedge clk);
    #1;
    m_redir = 0;
    if (!m_run && !m_halt) begin
      m_run = 1;
    end else if (m_run) begin
      if (tk) begin
`ifdef PC_MISALIGN_TRAP_EN
        if (tg[1:0] != 2'b00) begin
          m_halt = 1; m_run = 0; m_trap = 1; m_trap_pc = tg;
        end else
`endif
        begin
          m_pc = tg; m_redir = 1;
          if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        end
      end else if (rdy) begin
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic test_reset();
    imem.if_ready = 1'b1;
    ex_valid = 1; ex_kind = 7; ex_pc = 64'h200; ex_imm = 0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_tests++;
    if (imem.if_pc !== 64'h0 || imem.if_valid !== 1'b0 || redirect !== 1'b0 || taken_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_async: pc=%h valid=%b redir=%b cnt=%0d, need 0/0/0/0",
               imem.if_pc, imem.if_valid, redirect, taken_cnt);
    end
    clear_ex();
    #1;
    model_reset();
    reset = 1'b0;
    tick();
    n_tests++;
    if (imem.if_pc !== 64'h0 || imem.if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL boot_exit: pc=%h valid=%b, need 0/1", imem.if_pc, imem.if_valid);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    imem.if_ready = 1'b1;
    clear_ex();
    n_tests++;
    if (imem.if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_valid: valid=%b, need 0", imem.if_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (imem.if_pc !== 64'(4 * i) || imem.if_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_pc[%0d]: pc=%h valid=%b, need %h/1", i, imem.if_pc, imem.if_valid, 64'(4 * i));
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    imem.if_ready = 1'b1;
    clear_ex();
    tick(); tick(); tick();
    ex_valid = 1; ex_kind = 1; ex_pc = 64'd8; ex_imm = 64'd4; ex_eq = 1;
    tick();
    n_tests++;
    if (imem.if_pc !== 64'd16 || redirect !== 1'b1 || taken_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL beq_taken: pc=%h redir=%b cnt=%0d, need 10/1/1", imem.if_pc, redirect, taken_cnt);
    end
    clear_ex();
    tick();
    n_tests++;
    if (imem.if_pc !== 64'd20 || redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_pulse: pc=%h redir=%b, need 14/0", imem.if_pc, redirect);
    end
    do_reset();
    tick(); tick(); tick();
    ex_valid = 1; ex_kind = 1; ex_pc = 64'd8; ex_imm = 64'd4; ex_eq = 0;
    tick();
    n_tests++;
    if (imem.if_pc !== 64'd12 || redirect !== 1'b0 || taken_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL beq_not_taken: pc=%h redir=%b cnt=%0d, need c/0/0", imem.if_pc, redirect, taken_cnt);
    end
    clear_ex();
  endtask

  task automatic test_stall();
    imem.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (imem.if_pc !== 64'd12 || imem.if_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: pc=%h valid=%b, need c/1", i, imem.if_pc, imem.if_valid);
      end
    end
    ex_valid = 1; ex_kind = 2; ex_pc = 64'd12; ex_imm = 64'h10; ex_eq = 0;
    tick();
    n_tests++;
    if (imem.if_pc !== 64'd44 || redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_bne: pc=%h redir=%b, need 2c/1", imem.if_pc, redirect);
    end
    clear_ex();
    tick();
    n_tests++;
    if (imem.if_pc !== 64'd44 || redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_after: pc=%h redir=%b, need 2c/0", imem.if_pc, redirect);
    end
  endtask

  task automatic test_jalr_link();
    do_reset();
    imem.if_ready = 1'b1;
    clear_ex();
    tick();
    ex_valid = 1; ex_kind = 8; ex_pc = 64'h40; ex_rs1 = 64'h101; ex_imm = 64'd2;
    #1;
    n_tests++;
    if (link_addr !== 64'h44) begin
      n_fail++;
      $display("FAIL link_addr: got=%h need=44", link_addr);
    end
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    clear_ex();
    tick();
    n_tests++;
    if (trap !== 1'b1 || trap_pc !== 64'h102 || imem.if_valid !== 1'b0 || taken_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL trap: trap=%b trap_pc=%h valid=%b cnt=%0d, need 1/102/0/0",
               trap, trap_pc, imem.if_valid, taken_cnt);
    end
`else
    n_tests++;
    if (imem.if_pc !== 64'h102 || redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL jalr: pc=%h redir=%b, need 102/1", imem.if_pc, redirect);
    end
`endif
    do_reset();
    clear_ex();
    tick();
    ex_valid = 1; ex_kind = 5; ex_pc = 64'h0; ex_imm = 64'd8; ex_ltu = 1; ex_lt = 0;
    tick();
    n_tests++;
    if (imem.if_pc !== 64'd16 || redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL bltu: pc=%h redir=%b, need 10/1", imem.if_pc, redirect);
    end
    ex_kind = 3;
    tick();
    n_tests++;
    if (imem.if_pc !== 64'd20 || redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL blt: pc=%h redir=%b, need 14/0", imem.if_pc, redirect);
    end
    clear_ex();
  endtask

  task automatic test_wrap_saturate();
    int bad;
    do_reset();
    imem.if_ready = 1'b1;
    clear_ex();
    tick();
    ex_valid = 1; ex_kind = 7; ex_pc = 64'hFFFF_FFFF_FFFF_FFF8; ex_imm = 64'd8;
    tick();
    n_tests++;
    if (imem.if_pc !== 64'd8 || redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: pc=%h redir=%b, need 8/1", imem.if_pc, redirect);
    end
    ex_pc = 64'h100; ex_imm = 64'h0;
    bad = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (redirect !== 1'b1 || imem.if_pc !== 64'h100) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL back_to_back: %0d cycles lacked redirect pulse, need 0", bad);
    end
    n_tests++;
    if (taken_cnt !== 4'hF) begin
      n_fail++;
      $display("FAIL saturate: cnt=%0d need 15", taken_cnt);
    end
    // reset while a redirect is in flight and fetch is stalled
    imem.if_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (imem.if_pc !== 64'h0 || imem.if_valid !== 1'b0 || redirect !== 1'b0 || taken_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: pc=%h valid=%b redir=%b cnt=%0d, need 0/0/0/0",
               imem.if_pc, imem.if_valid, redirect, taken_cnt);
    end
    model_reset();
    reset = 1'b0;
    clear_ex();
  endtask

  task automatic test_random();
    int v;
    do_reset();
    clear_ex();
    for (int i = 0; i < 400; i++) begin
      imem.if_ready = 1'($urandom_range(0, 1));
      ex_valid = ($urandom_range(0, 2) == 0);
      ex_kind  = 4'($urandom_range(0, 15));
      ex_pc    = {32'h0, $urandom} & ~64'd3;
      v        = $urandom_range(0, 255);
      v        = (v - 128) & ~1;
      ex_imm   = 64'(v);
      ex_rs1   = {$urandom, $urandom};
      ex_eq    = 1'($urandom_range(0, 1));
      ex_lt    = 1'($urandom_range(0, 1));
      ex_ltu   = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (link_addr !== ex_pc + 64'd4) begin
        n_fail++;
        $display("FAIL rand_link[%0d]: got=%h need=%h", i, link_addr, ex_pc + 64'd4);
      end
      tick();
      n_tests++;
      if (imem.if_pc !== m_pc || imem.if_valid !== m_run || redirect !== m_redir || taken_cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: pc=%h valid=%b redir=%b cnt=%0d, need %h/%b/%b/%0d",
                 i, imem.if_pc, imem.if_valid, redirect, taken_cnt, m_pc, m_run, m_redir, m_cnt);
      end
`ifdef PC_MISALIGN_TRAP_EN
      n_tests++;
      if (trap !== m_trap || (m_trap && trap_pc !== m_trap_pc)) begin
        n_fail++;
        $display("FAIL rand_trap[%0d]: trap=%b pc=%h, need %b/%h", i, trap, trap_pc, m_trap, m_trap_pc);
      end
`endif
    end
    clear_ex();
  endtask

  initial begin
    reset = 1'b1;
    imem.if_ready = 1'b0;
    clear_ex();
    model_reset();
    #12;
    reset = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_jalr_link();
    test_wrap_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
